regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of every write-back value.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the conflict counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 The block SHALL have port hold, input, 1, pipeline stall: 1 means no grant is issued this cycle.
REQ-006 The block SHALL have ports alu_valid (input, 1), alu_ready (output, 1), alu_rd (input, 5) and alu_data (input, XLEN), forming the ALU write-back requester 0.
REQ-007 The block SHALL have ports mem_valid (input, 1), mem_ready (output, 1), mem_rd (input, 5) and mem_data (input, XLEN), forming the load-data requester 1.
REQ-008 The block SHALL have ports mdu_valid (input, 1), mdu_ready (output, 1), mdu_rd (input, 5) and mdu_data (input, XLEN), forming the multiply/divide requester 2.
REQ-009 The block SHALL have port rf_we, output, 1, the register-file write enable.
REQ-010 The block SHALL have port rf_waddr, output, 5, the register-file write address.
REQ-011 The block SHALL have port rf_wdata, output, XLEN, the register-file write data.
REQ-012 The block SHALL have port conflict_cnt, output, CNT_W, which counts cycles in which requesters conflicted.

Function
REQ-013 Each ready output SHALL be combinational from the valid inputs, hold and the arbitration state, and at most one ready SHALL be 1 in any cycle.
REQ-014 A transfer SHALL occur on requester i in a cycle where i_valid=1 and i_ready=1; a requester SHALL keep valid, rd and data stable until that transfer occurs.
REQ-015 If hold=0 and at least one valid is 1, exactly one valid requester SHALL be granted; if hold=1, all ready outputs SHALL be 0.
REQ-016 A transfer accepted in cycle N SHALL drive the write on the following cycle: rf_waddr=rd and rf_wdata=data, registered, with rf_we=1 in cycle N+1, giving 1-cycle latency.
REQ-017 A transfer with rd=0 SHALL be accepted, but rf_we SHALL be 0 in cycle N+1, so x0 is never written.
REQ-018 In a cycle with no transfer, rf_we SHALL be 0 in the next cycle, and rf_waddr and rf_wdata SHALL hold their previous values.
REQ-019 conflict_cnt SHALL increment by 1 in each cycle where hold=0 and two or more valid inputs are 1, and SHALL saturate at all-ones without wrapping.
REQ-020 Arbitration state (REQ-025) SHALL update only in cycles where a transfer occurs, and SHALL be unchanged during hold.
REQ-021 A requester that is not granted SHALL NOT lose its request; it SHALL be granted in a later cycle when arbitration selects it.

Reset
REQ-022 While rst=1, rf_we, rf_waddr, rf_wdata and conflict_cnt SHALL be 0 on the next edge, and all ready outputs SHALL be 0 during that cycle.
REQ-023 A transfer presented in a cycle where rst=1 SHALL NOT be accepted and SHALL NOT cause a write after reset deasserts.
REQ-024 Reset SHALL set the round-robin last-grant pointer to 2, so that requester 0 has first priority.

Configuration
REQ-025 With macro WB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: the search starts at (last_grant+1) mod 3, and last_grant updates to the granted index on each transfer.
REQ-026 With WB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority alu > mem > mdu, the pointer SHALL not exist, and REQ-024 SHALL not apply.

Verification
REQ-027 Single request: alu_valid=1, alu_rd=5, alu_data=0x12345678 for 1 cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x12345678; following cycle rf_we=0.
REQ-028 x0 drop: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF -> mem_ready=1; next cycle rf_we=0.
REQ-029 Conflict, round-robin: all three valid continuously from reset with rd=1/2/3 -> writes to rf_waddr 1,2,3,1 on consecutive cycles, and conflict_cnt=4 after 4 cycles. Without the macro: rf_waddr=1 on every cycle, with mem_ready and mdu_ready stuck at 0.
REQ-030 Hold: alu_valid=1 and hold=1 for 3 cycles -> alu_ready=0 and rf_we=0 throughout, conflict_cnt unchanged; drop hold -> write lands 1 cycle later.
REQ-031 Reset mid-operation: a transfer is accepted in cycle N and rst=1 in cycle N+1 -> rf_we=0, rf_waddr=0 and rf_wdata=0 after the edge; the next grant goes to alu with all three valid.
REQ-032 Saturation: with CNT_W=4, alu and mem valid for 20 cycles -> conflict_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: three requesters (ALU, load, MDU) share one write port.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority alu > mem > mdu.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [4:0]       mdu_rd,
  input  logic [XLEN-1:0]  mdu_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [2:0]       valid_s;
  logic [2:0]       grant_s;
  logic [1:0]       gidx_s;
  logic             xfer_s;
  logic             conflict_s;
  logic [4:0]       sel_rd_s;
  logic [XLEN-1:0]  sel_data_s;
  logic             rf_we_r;
  logic [4:0]       rf_waddr_r;
  logic [XLEN-1:0]  rf_wdata_r;
  logic [CNT_W-1:0] conflict_cnt_r;

  assign valid_s = {mdu_valid, mem_valid, alu_valid};

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] last_grant_r;

  // One-hot grant of the first valid requester searching upward from 'start', wrapping mod 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] start);
    logic [2:0] g;
    g = 3'b000;
    case (start)
      2'd0: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else           g = 3'b000;
      end
      2'd1: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else           g = 3'b000;
      end
      default: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else           g = 3'b000;
      end
    endcase
    return g;
  endfunction

  // Round-robin grant, search begins just after the last granted requester.
  always_comb begin
    grant_s = 3'b000;
    if (rst || hold) begin
      grant_s = 3'b000;
    end else begin
      case (last_grant_r)
        2'd0:    grant_s = rr_pick(valid_s, 2'd1);
        2'd1:    grant_s = rr_pick(valid_s, 2'd2);
        default: grant_s = rr_pick(valid_s, 2'd0);
      endcase
    end
  end

  // Pointer only moves on an actual transfer; reset favours requester 0 next.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 2'd2;
    end else if (xfer_s) begin
      last_grant_r <= gidx_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`else
  // Fixed-priority grant: alu over mem over mdu.
  always_comb begin
    grant_s = 3'b000;
    if (rst || hold) begin
      grant_s = 3'b000;
    end else if (valid_s[0]) begin
      grant_s = 3'b001;
    end else if (valid_s[1]) begin
      grant_s = 3'b010;
    end else if (valid_s[2]) begin
      grant_s = 3'b100;
    end else begin
      grant_s = 3'b000;
    end
  end
`endif

  assign xfer_s     = |grant_s;
  assign alu_ready  = grant_s[0];
  assign mem_ready  = grant_s[1];
  assign mdu_ready  = grant_s[2];
  assign conflict_s = !hold && ((valid_s[0] && valid_s[1]) || (valid_s[0] && valid_s[2]) ||
                                (valid_s[1] && valid_s[2]));

  // Encode the one-hot grant and select the winning rd/data.
  always_comb begin
    gidx_s     = 2'd0;
    sel_rd_s   = alu_rd;
    sel_data_s = alu_data;
    case (grant_s)
      3'b010: begin
        gidx_s     = 2'd1;
        sel_rd_s   = mem_rd;
        sel_data_s = mem_data;
      end
      3'b100: begin
        gidx_s     = 2'd2;
        sel_rd_s   = mdu_rd;
        sel_data_s = mdu_data;
      end
      default: begin
        gidx_s     = 2'd0;
        sel_rd_s   = alu_rd;
        sel_data_s = alu_data;
      end
    endcase
  end

  // Write port register: address/data follow every transfer, x0 writes are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= {XLEN{1'b0}};
    end else if (xfer_s) begin
      rf_we_r    <= (sel_rd_s != 5'd0);
      rf_waddr_r <= sel_rd_s;
      rf_wdata_r <= sel_data_s;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  // Saturating count of cycles with competing requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (conflict_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
      conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural arbitration model.
// Follows WB_ROUND_ROBIN_EN the same way the design does.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, hold;
  logic             v [3];
  logic [4:0]       rd [3];
  logic [XLEN-1:0]  dat [3];
  logic             alu_ready, mem_ready, mdu_ready;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic [CNT_W-1:0] conflict_cnt;

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_valid(v[0]), .alu_ready(alu_ready), .alu_rd(rd[0]), .alu_data(dat[0]),
    .mem_valid(v[1]), .mem_ready(mem_ready), .mem_rd(rd[1]), .mem_data(dat[1]),
    .mdu_valid(v[2]), .mdu_ready(mdu_ready), .mdu_rd(rd[2]), .mdu_data(dat[2]),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .conflict_cnt(conflict_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  int              m_last;
  logic            m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  int              m_cnt;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    int idx;
    if (rst || hold) return -1;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      idx = (m_last + k) % 3;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < 3; k++) begin
      idx = k;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  // One clock cycle: check readies, advance model at the edge, check registered outputs.
  task automatic step(output int g);
    int nv;
    logic [2:0] exp_rdy;
    #1;
    g = pick();
    exp_rdy = 3'b000;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_val("ready", {61'd0, mdu_ready, mem_ready, alu_ready}, {61'd0, exp_rdy});
    nv = int'(v[0]) + int'(v[1]) + int'(v[2]);
    @(posedge clk);
    if (rst) begin
      m_we = 1'b0; m_addr = 5'd0; m_data = '0; m_cnt = 0; m_last = 2;
    end else begin
      if (g >= 0) begin
        m_we = (rd[g] != 5'd0); m_addr = rd[g]; m_data = dat[g]; m_last = g;
      end else begin
        m_we = 1'b0;
      end
      if (!hold && nv >= 2 && m_cnt < CMAX) m_cnt++;
    end
    #1;
    check_val("rf_we", {63'd0, rf_we}, {63'd0, m_we});
    check_val("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_addr});
    check_val("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_data});
    check_val("conflict_cnt", {60'd0, conflict_cnt}, 64'(m_cnt));
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; rd[i] = 5'd0; dat[i] = '0;
    end
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    step(g);
    step(g);
    rst = 1'b0;
  endtask

  int g;
  logic [4:0] seq [4];
  logic [4:0] exp_seq [4];
  int cnt_before;

  initial begin
    rst = 1'b1; hold = 1'b0;
    idle_all();
    m_last = 2; m_we = 1'b0; m_addr = 5'd0; m_data = '0; m_cnt = 0;
    @(posedge clk); #1;
    do_reset();
    check_val("reset_cnt", {60'd0, conflict_cnt}, 64'd0);

    // Single ALU request
    v[0] = 1'b1; rd[0] = 5'd5; dat[0] = 32'h12345678;
    step(g);
    check_val("single_data", {32'd0, rf_wdata}, 64'h12345678);
    v[0] = 1'b0;
    step(g);
    check_val("single_we_off", {63'd0, rf_we}, 64'd0);

    // x0 drop on load requester
    v[1] = 1'b1; rd[1] = 5'd0; dat[1] = 32'hFFFFFFFF;
    step(g);
    check_val("x0_we", {63'd0, rf_we}, 64'd0);
    v[1] = 1'b0;

    // All three contending from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; rd[i] = 5'(i + 1); dat[i] = 32'hA0 + 32'(i);
    end
`ifdef WB_ROUND_ROBIN_EN
    exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd3; exp_seq[3] = 5'd1;
`else
    exp_seq[0] = 5'd1; exp_seq[1] = 5'd1; exp_seq[2] = 5'd1; exp_seq[3] = 5'd1;
`endif
    for (int c = 0; c < 4; c++) begin
      step(g);
      seq[c] = rf_waddr;
    end
    for (int c = 0; c < 4; c++) check_val("contend_addr", {59'd0, seq[c]}, {59'd0, exp_seq[c]});
    check_val("contend_cnt", {60'd0, conflict_cnt}, 64'd4);

    // Hold for three cycles, then release
    idle_all();
    v[0] = 1'b1; rd[0] = 5'd9; dat[0] = 32'hCAFE0009;
    hold = 1'b1;
    cnt_before = int'(conflict_cnt);
    for (int c = 0; c < 3; c++) step(g);
    check_val("hold_cnt", {60'd0, conflict_cnt}, 64'(cnt_before));
    hold = 1'b0;
    step(g);
    check_val("hold_release_addr", {59'd0, rf_waddr}, 64'd9);
    v[0] = 1'b0;

    // Reset right after an accepted transfer
    v[1] = 1'b1; rd[1] = 5'd7; dat[1] = 32'h0BADF00D;
    step(g);
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b1; rd[i] = 5'(i + 10); dat[i] = 32'h500 + 32'(i);
    end
    rst = 1'b1;
    step(g);
    check_val("rst_mid_addr", {59'd0, rf_waddr}, 64'd0);
    rst = 1'b0;
    step(g);
    check_val("rst_mid_alu_first", {59'd0, rf_waddr}, 64'd10);

    // Saturation of the conflict counter
    do_reset();
    idle_all();
    v[0] = 1'b1; rd[0] = 5'd3; dat[0] = 32'h33;
    v[1] = 1'b1; rd[1] = 5'd4; dat[1] = 32'h44;
    for (int c = 0; c < 20; c++) step(g);
    check_val("sat_cnt", {60'd0, conflict_cnt}, 64'(CMAX));

    // Randomized traffic; ungranted requests stay stable until accepted
    do_reset();
    idle_all();
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(4, 0) == 0);
      rst  = ($urandom_range(49, 0) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          v[i]   = 1'b1;
          rd[i]  = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
          dat[i] = $urandom;
        end
      end
      step(g);
      if (g >= 0) begin
        if ($urandom_range(1, 0) == 1) begin
          v[g] = 1'b0;
        end else begin
          rd[g]  = 5'($urandom_range(31, 0));
          dat[g] = $urandom;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
